hazard_ctrl: RTL and testbench

Central hazard and forwarding controller for the 5-stage RV32I pipeline. It keeps its own shadow copy of the destination-register state for the EX, MEM and WB stages. From that state it drives:
- the ID-stage RAW bypass selects (register-file data vs write-back data);
- the EX-stage operand forwarding selects;
- load-use stalls, and flushes on branch mispredict from the YAGS predictor.

It also keeps saturating performance counters for stall and flush cycles.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_match.sv | 15 +
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the RV32I hazard/forwarding controller: shadow pipeline slots
// and the EX operand forwarding select encoding.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } slot_t;

    // The EX slot also remembers which source registers its instruction reads.
    typedef struct packed {
        slot_t                 base;
        logic [REG_AW_DEF-1:0] rs1;
        logic [REG_AW_DEF-1:0] rs2;
        logic                  use_rs1;
        logic                  use_rs2;
    } ex_slot_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/hazard_match.sv
// "Slot writes register" comparator. With alu_only_i set, a load in the slot
// does not count, since its data is not available yet.
module hazard_match
    import hazard_pkg::*;
(
    input  slot_t                 slot_i,
    input  logic [REG_AW_DEF-1:0] reg_i,
    input  logic                  alu_only_i,
    output logic                  hit_o
);

    assign hit_o = slot_i.valid & slot_i.reg_write & (slot_i.rd == reg_i) &
                   (slot_i.rd != '0) & ~(alu_only_i & slot_i.mem_read);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline: shadow
// EX/MEM/WB destination state, bypass/forward selects, stall/flush, counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_mispredict,
    output logic              mux_sel_raw_id_rs1,
    output logic              mux_sel_raw_id_rs2,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_id,
    output logic              bubble_ex,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    ex_slot_t         ex_q, ex_d;
    slot_t            mem_q, wb_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_a_hit, mem_b_hit, wb_a_hit, wb_b_hit, wb_id1_hit, wb_id2_hit;
    logic load_use;
    logic mem_ld_a, mem_ld_b;

    hazard_match u_mem_a (.slot_i(mem_q), .reg_i(ex_q.rs1), .alu_only_i(1'b1), .hit_o(mem_a_hit));
    hazard_match u_mem_b (.slot_i(mem_q), .reg_i(ex_q.rs2), .alu_only_i(1'b1), .hit_o(mem_b_hit));
    hazard_match u_wb_a  (.slot_i(wb_q),  .reg_i(ex_q.rs1), .alu_only_i(1'b0), .hit_o(wb_a_hit));
    hazard_match u_wb_b  (.slot_i(wb_q),  .reg_i(ex_q.rs2), .alu_only_i(1'b0), .hit_o(wb_b_hit));
    hazard_match u_wb_i1 (.slot_i(wb_q),  .reg_i(id_rs1),   .alu_only_i(1'b0), .hit_o(wb_id1_hit));
    hazard_match u_wb_i2 (.slot_i(wb_q),  .reg_i(id_rs2),   .alu_only_i(1'b0), .hit_o(wb_id2_hit));

    assign load_use = id_valid & ex_q.base.valid & ex_q.base.mem_read & (ex_q.base.rd != '0) &
                      ((id_use_rs1 & (id_rs1 == ex_q.base.rd)) |
                       (id_use_rs2 & (id_rs2 == ex_q.base.rd)));

    // Every control output is forced low while reset is held, even mid-stall.
    always_comb begin
        stall_if           = 1'b0;
        stall_id           = 1'b0;
        flush_id           = 1'b0;
        bubble_ex          = 1'b0;
        mux_sel_raw_id_rs1 = 1'b0;
        mux_sel_raw_id_rs2 = 1'b0;
        fwd_a_sel          = FWD_REG;
        fwd_b_sel          = FWD_REG;
        if (!rst) begin
            if (ex_mispredict) begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (load_use) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
            mux_sel_raw_id_rs1 = id_use_rs1 & wb_id1_hit;
            mux_sel_raw_id_rs2 = id_use_rs2 & wb_id2_hit;
            if (ex_q.base.valid && ex_q.use_rs1) begin
                if (mem_a_hit)     fwd_a_sel = FWD_MEM;
                else if (wb_a_hit) fwd_a_sel = FWD_WB;
            end
            if (ex_q.base.valid && ex_q.use_rs2) begin
                if (mem_b_hit)     fwd_b_sel = FWD_MEM;
                else if (wb_b_hit) fwd_b_sel = FWD_WB;
            end
        end
    end

    always_comb begin
        ex_d = '0;
        if (!bubble_ex) begin
            ex_d.base.valid     = id_valid;
            ex_d.base.rd        = id_rd;
            ex_d.base.reg_write = id_reg_write;
            ex_d.base.mem_read  = id_mem_read;
            ex_d.rs1            = id_rs1;
            ex_d.rs2            = id_rs2;
            ex_d.use_rs1        = id_use_rs1;
            ex_d.use_rs2        = id_use_rs2;
        end
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_id && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_id && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q.base;
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // A load in MEM feeding the EX instruction means the load-use stall was missed.
    assign mem_ld_a = ex_q.base.valid & ex_q.use_rs1 & mem_q.valid & mem_q.reg_write &
                      mem_q.mem_read & (mem_q.rd == ex_q.rs1) & (mem_q.rd != '0);
    assign mem_ld_b = ex_q.base.valid & ex_q.use_rs2 & mem_q.valid & mem_q.reg_write &
                      mem_q.mem_read & (mem_q.rd == ex_q.rs2) & (mem_q.rd != '0);

    a_no_mem_load_fwd: assert property (@(posedge clk) disable iff (rst) !(mem_ld_a | mem_ld_b));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl against an in-flight
// instruction list model, plus directed pipeline scenarios.
module tb_hazard_ctrl;

    localparam int AW      = 5;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       u1;
        bit       u2;
        bit       rw;
        bit       ld;
    } instr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic          id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic          ex_mispredict = 1'b0;
    logic          mux_sel_raw_id_rs1, mux_sel_raw_id_rs2;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          stall_if, stall_id, flush_id, bubble_ex;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int     n_checks = 0;
    int     n_errors = 0;
    instr_t inflight_q[$];   // [0] oldest (WB) .. [2] youngest (EX)
    int     exp_stall_cnt = 0;
    int     exp_flush_cnt = 0;
    bit     last_stall = 1'b0;

    hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_mispredict(ex_mispredict),
        .mux_sel_raw_id_rs1(mux_sel_raw_id_rs1), .mux_sel_raw_id_rs2(mux_sel_raw_id_rs2),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .bubble_ex(bubble_ex),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit writes(instr_t p, bit [4:0] r);
        return p.valid && p.rw && (p.rd == r) && (r != 0);
    endfunction

    // Youngest older producer wins, but a load still in MEM has no data to give.
    function automatic bit [1:0] exp_fwd(bit en, bit [4:0] r, instr_t mem, instr_t wb);
        if (!en) return 2'b00;
        if (writes(mem, r) && !mem.ld) return 2'b01;
        if (writes(wb, r)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic instr_t empty_instr();
        instr_t e;
        e = '{default: 0};
        return e;
    endfunction

    task automatic model_reset();
        inflight_q = {};
        repeat (3) inflight_q.push_back(empty_instr());
        exp_stall_cnt = 0;
        exp_flush_cnt = 0;
        last_stall    = 1'b0;
    endtask

    task automatic set_id(input bit v, input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                          input bit u1, input bit u2, input bit rw, input bit ld);
        id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; id_reg_write = rw; id_mem_read = ld;
    endtask

    // Check outputs mid-cycle, then advance the model across the next rising edge.
    task automatic cycle();
        instr_t ex, mem, wb, nxt;
        bit lu, fl, st;
        @(negedge clk);
        ex = inflight_q[2]; mem = inflight_q[1]; wb = inflight_q[0];
        lu = id_valid && ex.valid && ex.ld && (ex.rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex.rd) || (id_use_rs2 && id_rs2 == ex.rd));
        fl = ex_mispredict;
        st = lu && !fl;
        check_val("stall_if",  stall_if,  st);
        check_val("stall_id",  stall_id,  st);
        check_val("flush_id",  flush_id,  fl);
        check_val("bubble_ex", bubble_ex, st || fl);
        check_val("fwd_a", fwd_a_sel, exp_fwd(ex.valid && ex.u1, ex.rs1, mem, wb));
        check_val("fwd_b", fwd_b_sel, exp_fwd(ex.valid && ex.u2, ex.rs2, mem, wb));
        check_val("byp_rs1", mux_sel_raw_id_rs1, id_use_rs1 && writes(wb, id_rs1));
        check_val("byp_rs2", mux_sel_raw_id_rs2, id_use_rs2 && writes(wb, id_rs2));
        check_val("stall_cnt", stall_cnt, exp_stall_cnt);
        check_val("flush_cnt", flush_cnt, exp_flush_cnt);
        @(posedge clk);
        nxt = empty_instr();
        if (!(st || fl)) begin
            nxt.valid = id_valid; nxt.rd = id_rd; nxt.rs1 = id_rs1; nxt.rs2 = id_rs2;
            nxt.u1 = id_use_rs1; nxt.u2 = id_use_rs2; nxt.rw = id_reg_write; nxt.ld = id_mem_read;
        end
        inflight_q.push_back(nxt);
        void'(inflight_q.pop_front());
        if (st && exp_stall_cnt < CNT_MAX) exp_stall_cnt++;
        if (fl && exp_flush_cnt < CNT_MAX) exp_flush_cnt++;
        last_stall = st;
        #1;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_stall_id", stall_id, 0);
        check_val("rst_fwd_a", fwd_a_sel, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // lw x5 ; add x6,x5,x7 -> one stall, then WB forward
        set_id(1, 5, 1, 0, 1, 0, 1, 1); cycle();
        set_id(1, 6, 5, 7, 1, 1, 1, 0); cycle();
        cycle();
        nop();
        nop(); nop();
        check_val("lu_stall_total", stall_cnt, 1);

        // add x5 ; sub x8,x5,x5 -> MEM forward on both operands
        set_id(1, 5, 1, 2, 1, 1, 1, 0); cycle();
        set_id(1, 8, 5, 5, 1, 1, 1, 0); cycle();
        nop(); nop(); nop();

        // two producers of x5, consumer sees the younger one in MEM
        set_id(1, 5, 1, 2, 1, 1, 1, 0); cycle();
        set_id(1, 5, 3, 4, 1, 1, 1, 0); cycle();
        set_id(1, 10, 5, 0, 1, 1, 1, 0); cycle();
        nop(); nop(); nop();

        // WB writes x9 while ID reads rs2=x9; then the same with x0
        set_id(1, 9, 1, 2, 1, 1, 1, 0); cycle();
        nop(); nop();
        set_id(1, 11, 3, 9, 1, 1, 1, 0); cycle();
        set_id(1, 0, 1, 2, 1, 1, 1, 0); cycle();
        nop(); nop();
        set_id(1, 12, 0, 0, 1, 1, 1, 0); cycle();
        nop(); nop(); nop();

        // mispredict coincident with load-use: flush wins
        set_id(1, 5, 1, 0, 1, 0, 1, 1); cycle();
        set_id(1, 6, 5, 7, 1, 1, 1, 0); ex_mispredict = 1'b1; cycle();
        ex_mispredict = 1'b0;
        nop(); nop(); nop();
        check_val("flush_total", flush_cnt, 1);
        check_val("stall_after_flush", stall_cnt, 1);

        // reset asserted mid-stall
        set_id(1, 5, 1, 0, 1, 0, 1, 1); cycle();
        set_id(1, 6, 5, 7, 1, 1, 1, 0);
        #2;
        check_val("pre_rst_stall", stall_id, 1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_stall_if",  stall_if,  0);
        check_val("mid_rst_stall_id",  stall_id,  0);
        check_val("mid_rst_bubble",    bubble_ex, 0);
        check_val("mid_rst_flush",     flush_id,  0);
        check_val("mid_rst_stall_cnt", stall_cnt, 0);
        check_val("mid_rst_flush_cnt", flush_cnt, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        cycle();
        nop(); nop(); nop();

        // randomized traffic, small register pool to provoke hazards
        for (int i = 0; i < 2500; i++) begin
            if (!(last_stall && $urandom_range(0, 9) < 8)) begin
                set_id($urandom_range(0, 99) < 85, 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 30);
            end
            ex_mispredict = $urandom_range(0, 99) < 8;
            cycle();
        end
        ex_mispredict = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
